// File: rtl/buffer_reader.sv
// Read-side consumer for the inter-producer data buffer: pops words with an
// rd_en/rd_valid handshake, holds each on the display bus and counts them.
module buffer_reader #(
    parameter int unsigned HOLD_TICKS = 2,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        drain,
    input  logic        clear,
    input  logic        tick,
    input  logic        buffer_empty,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic        rd_en,
    output logic [15:0] disp_data,
    output logic        disp_valid,
    output logic [7:0]  word_count,
    output logic        timeout_err,
    output logic        drained
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic [CW-1:0] word_count_nxt;
    logic [DW-1:0] disp_data_nxt;
    logic          disp_valid_nxt;
    logic          rd_en_nxt;
    logic          timeout_err_nxt;
    logic          latch;
    logic          can_pop;

    assign can_pop = enable && !buffer_empty;
    assign drained = (state == IDLE) && buffer_empty;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            hold_cnt    <= '0;
            rd_en       <= 1'b0;
            disp_data   <= '0;
            disp_valid  <= 1'b0;
            word_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            rd_en       <= rd_en_nxt;
            disp_data   <= disp_data_nxt;
            disp_valid  <= disp_valid_nxt;
            word_count  <= word_count_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        tmo_cnt_nxt     = tmo_cnt;
        hold_cnt_nxt    = hold_cnt;
        timeout_err_nxt = 1'b0;
        latch           = 1'b0;
        disp_data_nxt   = disp_data;
        disp_valid_nxt  = disp_valid;
        word_count_nxt  = word_count;

        case (state)
            IDLE: begin
                if (can_pop) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                tmo_cnt_nxt = '0;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (rd_valid) begin
                    latch        = 1'b1;
                    hold_cnt_nxt = CW'(HOLD_TICKS);
                    state_nxt    = HOLD;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CW'(1);
                    if (tmo_cnt_nxt == CW'(TIMEOUT)) begin
                        timeout_err_nxt = 1'b1;
                        state_nxt       = IDLE;
                    end
                end
            end
            HOLD: begin
                // A tick in the latch cycle is not seen here; counting starts in HOLD
                if (tick && (hold_cnt != '0)) begin
                    hold_cnt_nxt = hold_cnt - CW'(1);
                end
                if ((hold_cnt_nxt == '0) || drain) begin
                    state_nxt = can_pop ? REQ : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        rd_en_nxt = (state_nxt == REQ);

        // A latch overrides a coincident clear; the count restarts at one
        if (latch) begin
            disp_data_nxt  = rd_data;
            disp_valid_nxt = 1'b1;
            if (clear) begin
                word_count_nxt = CW'(1);
            end else if (word_count != '1) begin
                word_count_nxt = word_count + CW'(1);
            end
        end else if (clear) begin
            disp_data_nxt  = '0;
            disp_valid_nxt = 1'b0;
            word_count_nxt = '0;
        end
    end

endmodule

// File: tb/tb_buffer_reader.sv
// Randomized bench for buffer_reader: a queue-backed buffer and responder drive
// the block while a transaction-level model predicts every output each cycle.
module tb_buffer_reader;

    localparam int unsigned HOLD_TICKS = 2;
    localparam int unsigned TIMEOUT    = 8;
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_HOLD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0, drain = 1'b0, clear = 1'b0, tick = 1'b0;
    logic        buffer_empty = 1'b1, rd_valid = 1'b0;
    logic [15:0] rd_data = 16'h0;
    logic        rd_en, disp_valid, timeout_err, drained;
    logic [15:0] disp_data;
    logic [7:0]  word_count;

    always #5 clk = ~clk;

    buffer_reader #(.HOLD_TICKS(HOLD_TICKS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .drain(drain), .clear(clear),
        .tick(tick), .buffer_empty(buffer_empty), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_en(rd_en), .disp_data(disp_data),
        .disp_valid(disp_valid), .word_count(word_count),
        .timeout_err(timeout_err), .drained(drained)
    );

    int n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pop transaction seen from the spec's phase rules
    int          m_phase, m_waited, m_ticks, m_count;
    logic [15:0] m_disp;
    logic        m_valid, m_tmo;

    // Buffer contents, responder and stimulus knobs
    logic [15:0] buf_q[$];
    int  seq = 0;
    bit  pend = 0;
    int  pend_left = 0;
    bit  resp_fired;
    int  k_en = 0, k_tick = 0, k_drain = 0, k_clear = 0, k_spur = 0, k_fill = 0;
    int  k_dly_min = 0, k_dly_max = 0;
    bit  k_no_resp = 0, k_clear_on_resp = 0;
    int  cyc = 0, n_rd_en = 0, n_tmo = 0, last_tmo_t = 0;
    int  rd_en_t[$];

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_waited = 0; m_ticks = 0; m_count = 0;
        m_disp = 16'h0; m_valid = 1'b0; m_tmo = 1'b0;
    endtask

    task automatic model_update();
        bit latch;
        latch = 0;
        m_tmo = 1'b0;
        case (m_phase)
            P_IDLE: if (enable && !buffer_empty) m_phase = P_REQ;
            P_REQ: begin m_phase = P_WAIT; m_waited = 0; end
            P_WAIT: begin
                if (rd_valid) begin
                    latch = 1; m_ticks = HOLD_TICKS; m_phase = P_HOLD;
                end else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin m_tmo = 1'b1; m_phase = P_IDLE; end
                end
            end
            default: begin
                if (tick) m_ticks--;
                if (m_ticks == 0 || drain)
                    m_phase = (enable && !buffer_empty) ? P_REQ : P_IDLE;
            end
        endcase
        if (latch) begin
            m_disp = rd_data; m_valid = 1'b1;
            m_count = clear ? 1 : (m_count < 255 ? m_count + 1 : 255);
        end else if (clear) begin
            m_disp = 16'h0; m_valid = 1'b0; m_count = 0;
        end
    endtask

    // One clock: check outputs, then drive next inputs and advance the model
    task automatic step();
        @(negedge clk);
        cyc++;
        check_eq("rd_en", 32'(rd_en), 32'(m_phase == P_REQ));
        check_eq("timeout_err", 32'(timeout_err), 32'(m_tmo));
        check_eq("disp_data", 32'(disp_data), 32'(m_disp));
        check_eq("disp_valid", 32'(disp_valid), 32'(m_valid));
        check_eq("word_count", 32'(word_count), 32'(m_count));
        check_eq("drained", 32'(drained), 32'((m_phase == P_IDLE) && buffer_empty));
        if (rd_en) begin n_rd_en++; rd_en_t.push_back(cyc); end
        if (timeout_err) begin n_tmo++; last_tmo_t = cyc; end

        rd_valid = 1'b0; rd_data = 16'($urandom); resp_fired = 0;
        if (pend) begin
            if (pend_left == 0) begin
                rd_valid = 1'b1; resp_fired = 1; pend = 0;
                if (buf_q.size() > 0) rd_data = buf_q.pop_front();
            end else begin
                pend_left--;
            end
        end else if (pct(k_spur)) begin
            rd_valid = 1'b1;
        end
        if (rd_en) begin
            pend = !k_no_resp;
            pend_left = int'($urandom_range(k_dly_max, k_dly_min));
        end
        if (pct(k_fill)) begin buf_q.push_back(16'(seq)); seq++; end
        buffer_empty = (buf_q.size() == 0);
        enable = pct(k_en);
        tick   = pct(k_tick);
        drain  = (k_drain == 2) ? pct(50) : (k_drain == 1);
        clear  = pct(k_clear) || (k_clear_on_resp && resp_fired);
        model_update();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; drain = 1'b0; clear = 1'b0; tick = 1'b0; rd_valid = 1'b0;
        buf_q.delete(); pend = 0; buffer_empty = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_rd_en", 32'(rd_en), 32'd0);
        check_eq("rst_disp_data", 32'(disp_data), 32'd0);
        check_eq("rst_disp_valid", 32'(disp_valid), 32'd0);
        check_eq("rst_word_count", 32'(word_count), 32'd0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
        check_eq("rst_drained", 32'(drained), 32'd1);
        model_reset();
        n_rd_en = 0; n_tmo = 0; rd_en_t.delete();
        rst = 1'b1;
        model_update();
    endtask

    task automatic run_until_rd_en(input int max_cycles);
        int start;
        start = n_rd_en;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (n_rd_en > start) return;
        end
        check_eq("wait_rd_en_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int t0, start;

        // Reset and idle with enable high but nothing to read
        do_reset();
        k_en = 100;
        repeat (10) step();
        check_eq("idle_no_rd_en", 32'(n_rd_en), 32'd0);

        // Single word held for two ticks before the next pop
        do_reset();
        buf_q.push_back(16'hBEEF); buf_q.push_back(16'h1234);
        k_en = 100; k_tick = 0; k_drain = 0; k_dly_min = 0; k_dly_max = 0;
        repeat (8) step();
        check_eq("single_pops", 32'(n_rd_en), 32'd1);
        check_eq("single_data", 32'(disp_data), 32'hBEEF);
        check_eq("single_count", 32'(word_count), 32'd1);
        k_tick = 100; step(); k_tick = 0;
        repeat (3) step();
        check_eq("one_tick_no_pop", 32'(n_rd_en), 32'd1);
        k_tick = 100; step(); k_tick = 0;
        repeat (2) step();
        check_eq("two_ticks_pop", 32'(n_rd_en), 32'd2);
        repeat (4) step();

        // Drain burst of five words
        do_reset();
        for (int i = 1; i <= 5; i++) buf_q.push_back(16'(i));
        k_en = 100; k_drain = 1; k_tick = 0;
        repeat (25) step();
        check_eq("drain_pops", 32'(n_rd_en), 32'd5);
        for (int i = 1; i < rd_en_t.size(); i++)
            check_eq("drain_spacing", 32'(rd_en_t[i] - rd_en_t[i-1]), 32'd3);
        check_eq("drain_count", 32'(word_count), 32'd5);
        check_eq("drain_data", 32'(disp_data), 32'd5);
        check_eq("drain_drained", 32'(drained), 32'd1);

        // Handshake timeout
        do_reset();
        buf_q.push_back(16'h7777);
        k_en = 100; k_drain = 0; k_no_resp = 1;
        run_until_rd_en(10);
        t0 = cyc;
        k_en = 0;
        repeat (14) step();
        check_eq("tmo_pulses", 32'(n_tmo), 32'd1);
        check_eq("tmo_latency", 32'(last_tmo_t - t0), 32'd9);
        check_eq("tmo_count", 32'(word_count), 32'd0);
        k_no_resp = 0;

        // Saturation, clear, and clear coincident with a latch
        do_reset();
        for (int i = 0; i < 300; i++) buf_q.push_back(16'(i));
        k_en = 100; k_drain = 1;
        repeat (920) step();
        check_eq("sat_count", 32'(word_count), 32'd255);
        k_clear = 100; step(); k_clear = 0; step();
        check_eq("clear_count", 32'(word_count), 32'd0);
        check_eq("clear_valid", 32'(disp_valid), 32'd0);
        buf_q.push_back(16'h0042);
        k_clear_on_resp = 1;
        run_until_rd_en(10);
        step(); step();
        check_eq("clr_latch_data", 32'(disp_data), 32'h0042);
        check_eq("clr_latch_count", 32'(word_count), 32'd1);
        k_clear_on_resp = 0;

        // Enable drop during WAIT, then async reset during HOLD
        do_reset();
        buf_q.push_back(16'h00A1); buf_q.push_back(16'h00A2);
        k_en = 100; k_drain = 0; k_tick = 0; k_dly_min = 3; k_dly_max = 3;
        run_until_rd_en(10);
        k_en = 0; k_tick = 100;
        start = n_rd_en;
        repeat (20) step();
        check_eq("en_drop_no_pop", 32'(n_rd_en - start), 32'd0);
        check_eq("en_drop_data", 32'(disp_data), 32'h00A1);
        k_en = 100; k_tick = 0; k_dly_min = 0; k_dly_max = 0;
        run_until_rd_en(10);
        repeat (3) step();
        check_eq("hold_count", 32'(word_count), 32'd2);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rd_en", 32'(rd_en), 32'd0);
        check_eq("async_disp_data", 32'(disp_data), 32'd0);
        check_eq("async_disp_valid", 32'(disp_valid), 32'd0);
        check_eq("async_word_count", 32'(word_count), 32'd0);
        do_reset();
        k_en = 0; k_spur = 100;
        repeat (3) step();
        k_spur = 0;

        // Randomized mixes against the model
        for (int r = 0; r < 6; r++) begin
            k_en = int'($urandom_range(100, 40)); k_tick = int'($urandom_range(80, 10));
            k_drain = int'($urandom_range(2)); k_clear = int'($urandom_range(5));
            k_spur = int'($urandom_range(20)); k_fill = int'($urandom_range(60, 10));
            k_dly_min = 0; k_dly_max = int'($urandom_range(TIMEOUT + 2));
            repeat (300) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_reader.md
# buffer_reader

Read-side consumer for the inter-producer data buffer. It pops 16-bit words from the buffer with an `rd_en`/`rd_valid` handshake and holds each word on the display bus for a programmable number of slow ticks. It counts consumed words and reports when the buffer is fully drained, which gives the control FSM its exit condition from the buffer-empty state. It sits between the buffer's read port and the display multiplexer, all in one clock domain.

## Interface
Parameters:
- `HOLD_TICKS`, default 2: number of `tick` pulses a word stays on `disp_data` before the next pop (range 1-255).
- `TIMEOUT`, default 8: number of `clk` cycles to wait for `rd_valid` after `rd_en` before aborting (range 1-255).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `enable`  in  1  consumption allowed; level-sensitive.
- `drain`  in  1  fast-drain mode; skips hold timing. Asserted by control in the buffer-empty state.
- `clear`  in  1  synchronous clear of `word_count`, `disp_data` and `disp_valid`.
- `tick`  in  1  single-cycle slow-rate strobe.
- `buffer_empty`  in  1  buffer has no readable word.
- `rd_valid`  in  1  `rd_data` valid this cycle.
- `rd_data`  in  16  word from buffer.
- `rd_en`  out  1  single-cycle pop request.
- `disp_data`  out  16  word currently shown.
- `disp_valid`  out  1  `disp_data` holds a consumed word.
- `word_count`  out  8  words consumed, saturating.
- `timeout_err`  out  1  single-cycle pulse on handshake timeout.
- `drained`  out  1  high when state is IDLE and `buffer_empty`=1.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Reset state is IDLE.
- IDLE: if `enable`=1 and `buffer_empty`=0, go to REQ; otherwise stay.
- REQ: `rd_en`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT unconditionally.
- WAIT:
  - If `rd_valid`=1: latch `rd_data` into `disp_data`, set `disp_valid`=1, increment `word_count` (saturating at 255), load the hold counter with `HOLD_TICKS`, and go to HOLD.
  - Otherwise increment the timeout counter. When it reaches `TIMEOUT`, pulse `timeout_err`, go to IDLE, and leave `disp_data` unchanged.
- HOLD:
  - Each cycle with `tick`=1 decrements the hold counter.
  - When the counter reaches 0, or whenever `drain`=1: if `enable`=1 and `buffer_empty`=0, go directly to REQ; otherwise go to IDLE.
- `rd_valid` outside WAIT is ignored: no latch, no count.
- `enable` falling during REQ, WAIT or HOLD: the current transaction completes and the block then parks in IDLE. A pop already requested is never abandoned.
- `clear`:
  - Zeroes `word_count` and `disp_data` and drops `disp_valid`; state is unaffected.
  - If `clear` and a WAIT latch occur in the same cycle, the latch wins for `disp_data`/`disp_valid`, and `word_count` becomes 1.
- `disp_valid` stays 1 after HOLD ends, so the display keeps showing the last word until the next latch or `clear`.
- `drained` is combinational from the state and `buffer_empty`.

## Timing
- Reset values: `rd_en`=0, `disp_data`=16'h0000, `disp_valid`=0, `word_count`=0, `timeout_err`=0, state IDLE, both internal counters 0. `drained` then follows `buffer_empty`.
- Reset asserted mid-transaction: the block enters IDLE immediately. Any pending `rd_valid` after release is ignored.
- Latencies:
  - `buffer_empty` falls (with `enable`=1 in IDLE) → `rd_en` high 1 cycle later.
  - `rd_valid` in WAIT → `disp_data`, `disp_valid` and `word_count` updated on that same clock edge (visible next cycle).
  - Back-to-back pop: the last HOLD cycle goes to REQ, so `rd_en` pulses occur at least 3 cycles apart (REQ, WAIT, HOLD).
  - Timeout: `timeout_err` pulses in the cycle after the `TIMEOUT`-th WAIT cycle without `rd_valid`.
- `tick` coinciding with the latch cycle does not decrement the hold counter. Counting starts in the first HOLD cycle.
- With `drain`=1 a full pop cycle takes 3 clocks when `rd_valid` returns immediately.

## Test plan
- Reset and idle: hold `rst`=0, then release with `buffer_empty`=1, `enable`=1 → all outputs at reset values, `drained`=1, `rd_en` never pulses.
- Single word: provide one word 16'hBEEF, responder returns `rd_valid` 1 cycle after `rd_en`, `HOLD_TICKS`=2 → `disp_data`=BEEF, `word_count`=1, next `rd_en` only after 2 `tick` pulses.
- Drain burst: preload 5 words 1..5, `drain`=1, `tick`=0 → five `rd_en` pulses spaced 3 cycles apart, `word_count`=5, `disp_data`=5, then `drained`=1.
- Timeout: `TIMEOUT`=8, responder never asserts `rd_valid` → exactly one `timeout_err` pulse 9 cycles after `rd_en`, state returns to IDLE, `word_count` unchanged.
- Saturation and clear: consume 300 words → `word_count`=255. Pulse `clear` → `word_count`=0, `disp_valid`=0. Then `clear` coincident with a latch of 16'h0042 → `disp_data`=0042, `word_count`=1.
- Enable drop and async reset: drop `enable` during WAIT → the word is still latched, then IDLE with no further `rd_en`. Assert `rst` during HOLD → outputs return to reset values immediately, without waiting for a clock edge.
